// File: rtl/onchip_mem_arbiter.sv
// -----------------------------------------------------------------------------
// onchip_mem_arbiter
//
// Shares one single-port on-chip memory (registered read data, one-cycle read
// latency) between two Avalon-style masters:
//   port 0 : Nios data master
//   port 1 : debug / loader master
//
// One transfer is granted per cycle. Arbitration is round-robin: a lone
// requester is granted, and a tie goes to the master that was not granted
// last time. The memory address/control lines are a combinational mux of the
// granted master. Reads are tagged with the issuing port and the memory's
// read data is registered back to that port two cycles after acceptance,
// together with a one-cycle readdatavalid strobe.
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   mN_address/byteenable/read/write/writedata/debugaccess
//                                request side of master N (N = 0, 1)
//   mN_waitrequest               request present but not accepted this cycle
//   mN_readdata/readdatavalid    registered read return to master N
//   mem_address/byteenable/chipselect/write/writedata/debugaccess/clken
//                                drive of the memory instance
//   mem_readdata                 memory read data, valid one cycle after issue
// -----------------------------------------------------------------------------
module onchip_mem_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,

  // master 0
  input  logic [ADDR_W-1:0]     m0_address,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W-1:0]     m0_writedata,
  input  logic                  m0_debugaccess,
  output logic                  m0_waitrequest,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,

  // master 1
  input  logic [ADDR_W-1:0]     m1_address,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W-1:0]     m1_writedata,
  input  logic                  m1_debugaccess,
  output logic                  m1_waitrequest,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,

  // memory side
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic                  mem_debugaccess,
  output logic                  mem_clken,
  input  logic [DATA_W-1:0]     mem_readdata
);

  localparam int BE_W = DATA_W / 8;

  // ---------------------------------------------------------------------------
  // Round-robin grant for two requesters.
  // last = index of the master granted by the previous accepted transfer.
  // Result is one-hot {grant1, grant0}, or zero when nobody requests.
  // ---------------------------------------------------------------------------
  function automatic logic [1:0] rr_grant(input logic r0, input logic r1,
                                          input logic last);
    logic [1:0] g;
    case ({r1, r0})
      2'b01:   g = 2'b01;
      2'b10:   g = 2'b10;
      2'b11:   g = last ? 2'b01 : 2'b10;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic              clken_r;       // memory clock enable, set on first edge out of reset
  logic              last_grant_r;  // port of the last accepted transfer
  logic              rd_pend_r;     // read issued to memory on the previous edge
  logic              rd_tag_r;      // port that issued that read
  logic              rdv0_r;
  logic              rdv1_r;
  logic [DATA_W-1:0] rdata0_r;
  logic [DATA_W-1:0] rdata1_r;

  // ---------------------------------------------------------------------------
  // Combinational signals
  // ---------------------------------------------------------------------------
  logic              req0_s;
  logic              req1_s;
  logic [1:0]        gnt_s;
  logic              accept_s;
  logic              rd_accept_s;
  logic [ADDR_W-1:0] mux_address_s;
  logic [BE_W-1:0]   mux_byteenable_s;
  logic              mux_write_s;
  logic [DATA_W-1:0] mux_writedata_s;
  logic              mux_debugaccess_s;

  // A write wins over a simultaneous read, but either one is a request.
  assign req0_s = m0_read | m0_write;
  assign req1_s = m1_read | m1_write;

  // Grant is blocked in reset and until the memory clock enable is up, so no
  // transfer is presented to the memory while it would ignore it.
  always_comb begin
    gnt_s = 2'b00;
    if (reset_n && clken_r) begin
      gnt_s = rr_grant(req0_s, req1_s, last_grant_r);
    end else begin
      gnt_s = 2'b00;
    end
  end

  assign accept_s = gnt_s[0] | gnt_s[1];

  // A requesting master waits unless granted; both wait throughout reset.
  assign m0_waitrequest = ~reset_n | (req0_s & ~gnt_s[0]);
  assign m1_waitrequest = ~reset_n | (req1_s & ~gnt_s[1]);

  // Memory-side mux of the granted master; everything is zero when idle.
  always_comb begin
    mux_address_s     = {ADDR_W{1'b0}};
    mux_byteenable_s  = {BE_W{1'b0}};
    mux_write_s       = 1'b0;
    mux_writedata_s   = {DATA_W{1'b0}};
    mux_debugaccess_s = 1'b0;
    rd_accept_s       = 1'b0;
    case (gnt_s)
      2'b01: begin
        mux_address_s     = m0_address;
        mux_byteenable_s  = m0_byteenable;
        mux_write_s       = m0_write;
        mux_writedata_s   = m0_writedata;
        mux_debugaccess_s = m0_debugaccess;
        rd_accept_s       = m0_read & ~m0_write;
      end
      2'b10: begin
        mux_address_s     = m1_address;
        mux_byteenable_s  = m1_byteenable;
        mux_write_s       = m1_write;
        mux_writedata_s   = m1_writedata;
        mux_debugaccess_s = m1_debugaccess;
        rd_accept_s       = m1_read & ~m1_write;
      end
      default: begin
        mux_address_s     = {ADDR_W{1'b0}};
        mux_byteenable_s  = {BE_W{1'b0}};
        mux_write_s       = 1'b0;
        mux_writedata_s   = {DATA_W{1'b0}};
        mux_debugaccess_s = 1'b0;
        rd_accept_s       = 1'b0;
      end
    endcase
  end

  assign mem_address     = mux_address_s;
  assign mem_byteenable  = mux_byteenable_s;
  assign mem_chipselect  = accept_s;
  assign mem_write       = mux_write_s;
  assign mem_writedata   = mux_writedata_s;
  assign mem_debugaccess = mux_debugaccess_s;
  assign mem_clken       = clken_r;

  // Memory clock enable: low in reset, high from the first edge afterwards.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clken_r <= 1'b0;
    end else begin
      clken_r <= 1'b1;
    end
  end

  // Round-robin history: remember which port took the last accepted transfer.
  // Reset value 1 makes master 0 win the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_r <= 1'b1;
    end else if (accept_s) begin
      last_grant_r <= gnt_s[1];
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

  // Read stage 1: note that a read went to the memory and which port owns it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend_r <= 1'b0;
      rd_tag_r  <= 1'b0;
    end else if (rd_accept_s) begin
      rd_pend_r <= 1'b1;
      rd_tag_r  <= gnt_s[1];
    end else begin
      rd_pend_r <= 1'b0;
      rd_tag_r  <= rd_tag_r;
    end
  end

  // Read stage 2, port 0: capture memory data and strobe valid when tagged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdv0_r   <= 1'b0;
      rdata0_r <= {DATA_W{1'b0}};
    end else if (rd_pend_r && !rd_tag_r) begin
      rdv0_r   <= 1'b1;
      rdata0_r <= mem_readdata;
    end else begin
      rdv0_r   <= 1'b0;
      rdata0_r <= rdata0_r;
    end
  end

  // Read stage 2, port 1: capture memory data and strobe valid when tagged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdv1_r   <= 1'b0;
      rdata1_r <= {DATA_W{1'b0}};
    end else if (rd_pend_r && rd_tag_r) begin
      rdv1_r   <= 1'b1;
      rdata1_r <= mem_readdata;
    end else begin
      rdv1_r   <= 1'b0;
      rdata1_r <= rdata1_r;
    end
  end

  assign m0_readdatavalid = rdv0_r;
  assign m0_readdata      = rdata0_r;
  assign m1_readdatavalid = rdv1_r;
  assign m1_readdata      = rdata1_r;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for onchip_mem_arbiter: a directed vector table, a reset-during-read
// sequence, and randomized traffic checked against a transaction-level model
// (grant rule, reference memory array, queue of outstanding reads).
// -----------------------------------------------------------------------------
module tb_onchip_mem_arbiter;

  localparam int AW = 9;
  localparam int DW = 32;
  localparam int BW = 4;

  logic clk = 1'b0;
  logic reset_n;

  logic [1:0]           rd, wr, dbg;
  logic [1:0][AW-1:0]   addr;
  logic [1:0][BW-1:0]   be;
  logic [1:0][DW-1:0]   wdata;
  logic [1:0]           wt, rv;
  logic [1:0][DW-1:0]   rdata;

  logic [AW-1:0] mem_address;
  logic [BW-1:0] mem_byteenable;
  logic          mem_chipselect, mem_write, mem_debugaccess, mem_clken;
  logic [DW-1:0] mem_writedata, mem_readdata;

  onchip_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(addr[0]), .m0_byteenable(be[0]), .m0_read(rd[0]), .m0_write(wr[0]),
    .m0_writedata(wdata[0]), .m0_debugaccess(dbg[0]), .m0_waitrequest(wt[0]),
    .m0_readdata(rdata[0]), .m0_readdatavalid(rv[0]),
    .m1_address(addr[1]), .m1_byteenable(be[1]), .m1_read(rd[1]), .m1_write(wr[1]),
    .m1_writedata(wdata[1]), .m1_debugaccess(dbg[1]), .m1_waitrequest(wt[1]),
    .m1_readdata(rdata[1]), .m1_readdatavalid(rv[1]),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_debugaccess(mem_debugaccess),
    .mem_clken(mem_clken), .mem_readdata(mem_readdata)
  );

  always #5 clk = ~clk;

  // Memory instance: registered read, byte-lane writes gated by debugaccess.
  logic [DW-1:0] mem_arr [0:511];
  initial begin
    for (int i = 0; i < 512; i++) mem_arr[i] = 32'h0;
    mem_readdata = 32'h0;
    forever begin
      @(posedge clk);
      if (mem_clken && mem_chipselect) begin
        if (mem_write) begin
          if (mem_debugaccess)
            for (int b = 0; b < BW; b++)
              if (mem_byteenable[b]) mem_arr[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
        end else begin
          mem_readdata <= mem_arr[mem_address];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model state
  // ---------------------------------------------------------------------------
  typedef struct { int port; logic [31:0] data; int due; } rd_t;
  rd_t            pend_q[$];
  logic [DW-1:0]  ref_mem [0:511];
  bit             last_win;
  bit             clk_en_exp;
  logic [1:0][DW-1:0] exp_rd;
  bit   [1:0]     acc;
  logic [1:0]     obs_rv;
  logic [1:0][DW-1:0] obs_rd;
  int             cyc;
  int             n_chk, n_pass;

  typedef struct {
    logic rst;
    logic [1:0] r, w, g;
    logic [1:0][8:0] a;
    logic [1:0][31:0] d;
    logic [1:0][3:0] be;
    logic [1:0] ewt;
    logic ecs;
    logic [8:0] eaddr;
    logic ewr;
    logic [1:0] erv;
    logic [31:0] erd;
  } vec_t;
  vec_t tbl[$];
  vec_t none;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic row(input logic rst, input logic [1:0] r, input logic [1:0] w,
                     input logic [8:0] a0, input logic [8:0] a1,
                     input logic [31:0] d0, input logic [31:0] d1,
                     input logic [3:0] be0, input logic [3:0] be1, input logic [1:0] g,
                     input logic [1:0] ewt, input logic ecs, input logic [8:0] eaddr,
                     input logic ewr, input logic [1:0] erv, input logic [31:0] erd);
    vec_t v;
    v.rst = rst; v.r = r; v.w = w; v.g = g;
    v.a[0] = a0; v.a[1] = a1; v.d[0] = d0; v.d[1] = d1; v.be[0] = be0; v.be[1] = be1;
    v.ewt = ewt; v.ecs = ecs; v.eaddr = eaddr; v.ewr = ewr; v.erv = erv; v.erd = erd;
    tbl.push_back(v);
  endtask

  task automatic rdrow(input logic [1:0] r, input logic [8:0] a0, input logic [8:0] a1,
                       input logic [1:0] ewt, input logic [8:0] eaddr,
                       input logic [1:0] erv, input logic [31:0] erd);
    row(1'b1, r, 2'b00, a0, a1, 32'h0, 32'h0, 4'hF, 4'hF, 2'b11, ewt, 1'b1, eaddr, 1'b0, erv, erd);
  endtask

  task automatic idle(input logic [1:0] erv, input logic [31:0] erd);
    row(1'b1, 2'b00, 2'b00, 9'h0, 9'h0, 32'h0, 32'h0, 4'hF, 4'hF, 2'b11,
        2'b00, 1'b0, 9'h0, 1'b0, erv, erd);
  endtask

  // One clock cycle: model decides what should happen, outputs are compared at
  // the falling edge, the model commits accepted transfers, inputs change #1
  // after the rising edge.
  task automatic step(input bit use_t, input vec_t v);
    int win;
    logic [1:0] req, e_wt, e_rv;
    logic [AW-1:0] e_addr;
    logic [BW-1:0] e_be;
    logic [DW-1:0] e_wd;
    logic e_wr, e_dbg;
    @(negedge clk);
    if (!reset_n) begin
      pend_q.delete(); last_win = 1'b1; exp_rd = '0; clk_en_exp = 1'b0;
    end
    req = rd | wr;
    win = -1;
    if (reset_n && clk_en_exp) begin
      if (req == 2'b11) win = last_win ? 0 : 1;
      else if (req[0]) win = 0;
      else if (req[1]) win = 1;
    end
    for (int p = 0; p < 2; p++) e_wt[p] = !reset_n || (req[p] && (win != p));
    e_addr = '0; e_be = '0; e_wd = '0; e_wr = 1'b0; e_dbg = 1'b0;
    if (win >= 0) begin
      e_addr = addr[win]; e_be = be[win]; e_wd = wdata[win]; e_wr = wr[win]; e_dbg = dbg[win];
    end
    e_rv = 2'b00;
    if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
      e_rv[pend_q[0].port] = 1'b1;
      exp_rd[pend_q[0].port] = pend_q[0].data;
      void'(pend_q.pop_front());
    end
    chk("m0_waitrequest", wt[0], e_wt[0]);
    chk("m1_waitrequest", wt[1], e_wt[1]);
    chk("mem_chipselect", mem_chipselect, win >= 0);
    chk("mem_address", mem_address, e_addr);
    chk("mem_byteenable", mem_byteenable, e_be);
    chk("mem_writedata", mem_writedata, e_wd);
    chk("mem_write", mem_write, e_wr);
    chk("mem_debugaccess", mem_debugaccess, e_dbg);
    chk("mem_clken", mem_clken, clk_en_exp);
    chk("m0_readdatavalid", rv[0], e_rv[0]);
    chk("m1_readdatavalid", rv[1], e_rv[1]);
    chk("m0_readdata", rdata[0], exp_rd[0]);
    chk("m1_readdata", rdata[1], exp_rd[1]);
    obs_rv = rv; obs_rd = rdata;
    if (use_t) begin
      chk("tbl_waitrequest", wt, v.ewt);
      chk("tbl_chipselect", mem_chipselect, v.ecs);
      if (v.ecs) begin
        chk("tbl_mem_address", mem_address, v.eaddr);
        chk("tbl_mem_write", mem_write, v.ewr);
      end
      chk("tbl_readdatavalid", rv, v.erv);
      for (int p = 0; p < 2; p++)
        if (v.erv[p]) chk("tbl_readdata", rdata[p], v.erd);
    end
    acc = 2'b00;
    if (win >= 0) begin
      acc[win] = 1'b1;
      last_win = (win == 1);
      if (wr[win]) begin
        if (dbg[win])
          for (int b = 0; b < BW; b++)
            if (be[win][b]) ref_mem[addr[win]][b*8 +: 8] = wdata[win][b*8 +: 8];
      end else begin
        pend_q.push_back('{port: win, data: ref_mem[addr[win]], due: cyc + 2});
      end
    end
    @(posedge clk);
    if (reset_n) clk_en_exp = 1'b1;
    cyc++;
    #1;
  endtask

  initial begin
    logic [1:0] seen;
    int r;
    reset_n = 1'b1; rd = '0; wr = '0; dbg = '0; addr = '0; be = '0; wdata = '0;
    cyc = 0; n_chk = 0; n_pass = 0; last_win = 1'b1; clk_en_exp = 1'b0;
    exp_rd = '0; acc = '0; obs_rv = '0; obs_rd = '0;
    for (int i = 0; i < 512; i++) ref_mem[i] = 32'h0;
    #1 reset_n = 1'b0;

    // Reset with both requesting, release, first tie to m0.
    row(1'b0, 2'b11, 2'b00, 9'h0, 9'h0, 32'h0, 32'h0, 4'hF, 4'hF, 2'b11, 2'b11, 1'b0, 9'h0, 1'b0, 2'b00, 32'h0);
    row(1'b0, 2'b11, 2'b00, 9'h0, 9'h0, 32'h0, 32'h0, 4'hF, 4'hF, 2'b11, 2'b11, 1'b0, 9'h0, 1'b0, 2'b00, 32'h0);
    row(1'b1, 2'b11, 2'b00, 9'h0, 9'h0, 32'h0, 32'h0, 4'hF, 4'hF, 2'b11, 2'b11, 1'b0, 9'h0, 1'b0, 2'b00, 32'h0);
    rdrow(2'b11, 9'h10, 9'h11, 2'b10, 9'h10, 2'b00, 32'h0);
    rdrow(2'b10, 9'h00, 9'h11, 2'b00, 9'h11, 2'b00, 32'h0);
    // Single read by m1 after its write.
    row(1'b1, 2'b00, 2'b10, 9'h0, 9'h05, 32'h0, 32'hDEADBEEF, 4'hF, 4'hF, 2'b11, 2'b00, 1'b1, 9'h05, 1'b1, 2'b01, 32'h0);
    rdrow(2'b10, 9'h00, 9'h05, 2'b00, 9'h05, 2'b10, 32'h0);
    idle(2'b00, 32'h0);
    idle(2'b10, 32'hDEADBEEF);
    // Write without debugaccess is accepted but ignored.
    row(1'b1, 2'b00, 2'b01, 9'h05, 9'h0, 32'h12345678, 32'h0, 4'hF, 4'hF, 2'b10, 2'b00, 1'b1, 9'h05, 1'b1, 2'b00, 32'h0);
    rdrow(2'b01, 9'h05, 9'h00, 2'b00, 9'h05, 2'b00, 32'h0);
    idle(2'b00, 32'h0);
    idle(2'b01, 32'hDEADBEEF);
    // Byte lanes on the top address; read right after the write.
    row(1'b1, 2'b00, 2'b01, 9'h1FF, 9'h0, 32'h11223344, 32'h0, 4'hF, 4'hF, 2'b11, 2'b00, 1'b1, 9'h1FF, 1'b1, 2'b00, 32'h0);
    row(1'b1, 2'b00, 2'b10, 9'h0, 9'h1FF, 32'h0, 32'h000000AA, 4'hF, 4'h1, 2'b11, 2'b00, 1'b1, 9'h1FF, 1'b1, 2'b00, 32'h0);
    rdrow(2'b01, 9'h1FF, 9'h00, 2'b00, 9'h1FF, 2'b00, 32'h0);
    idle(2'b00, 32'h0);
    idle(2'b01, 32'h112233AA);
    // Contention: m1 takes one first so the alternation starts with m0.
    rdrow(2'b10, 9'h00, 9'h05, 2'b00, 9'h05, 2'b00, 32'h0);
    rdrow(2'b11, 9'h05, 9'h1FF, 2'b10, 9'h05, 2'b00, 32'h0);
    rdrow(2'b11, 9'h1FF, 9'h1FF, 2'b01, 9'h1FF, 2'b10, 32'hDEADBEEF);
    rdrow(2'b11, 9'h1FF, 9'h05, 2'b10, 9'h1FF, 2'b01, 32'hDEADBEEF);
    rdrow(2'b11, 9'h10, 9'h05, 2'b01, 9'h05, 2'b10, 32'h112233AA);
    rdrow(2'b11, 9'h10, 9'h1FF, 2'b10, 9'h10, 2'b01, 32'h112233AA);
    rdrow(2'b11, 9'h05, 9'h1FF, 2'b01, 9'h1FF, 2'b10, 32'hDEADBEEF);
    rdrow(2'b11, 9'h05, 9'h11, 2'b10, 9'h05, 2'b01, 32'h0);
    rdrow(2'b11, 9'h10, 9'h11, 2'b01, 9'h11, 2'b10, 32'h112233AA);
    rdrow(2'b01, 9'h10, 9'h00, 2'b00, 9'h10, 2'b01, 32'hDEADBEEF);
    idle(2'b10, 32'h0);
    idle(2'b01, 32'h0);
    idle(2'b00, 32'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      reset_n = tbl[i].rst; rd = tbl[i].r; wr = tbl[i].w; dbg = tbl[i].g;
      addr = tbl[i].a; wdata = tbl[i].d; be = tbl[i].be;
      step(1'b1, tbl[i]);
    end

    // Reset right after a read is accepted: that read never returns.
    rd = 2'b01; wr = 2'b00; dbg = 2'b11; be = {4'hF, 4'hF}; addr[0] = 9'h05;
    step(1'b0, none);
    rd = 2'b00; reset_n = 1'b0;
    step(1'b0, none); seen = obs_rv;
    reset_n = 1'b1;
    step(1'b0, none); seen |= obs_rv;
    step(1'b0, none); seen |= obs_rv;
    step(1'b0, none); seen |= obs_rv;
    chk("reset_drops_read", seen, 2'b00);
    rd = 2'b01; addr[0] = 9'h1FF;
    step(1'b0, none);
    rd = 2'b00;
    step(1'b0, none);
    step(1'b0, none);
    chk("post_reset_valid", obs_rv, 2'b01);
    chk("post_reset_data", obs_rd[0], 32'h112233AA);

    // Randomized traffic; a master keeps its request while it is waiting.
    for (int n = 0; n < 800; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (!((rd[p] | wr[p]) && !acc[p])) begin
          r = $urandom_range(0, 9);
          rd[p] = (r >= 3 && r <= 6) || (r == 9);
          wr[p] = (r >= 7);
          addr[p] = ($urandom_range(0, 3) == 0) ? 9'(9'h1F8 + $urandom_range(0, 7))
                                                : 9'($urandom_range(0, 7));
          be[p] = 4'($urandom_range(0, 15));
          wdata[p] = $urandom;
          dbg[p] = ($urandom_range(0, 3) != 0);
        end
      end
      reset_n = ($urandom_range(0, 149) != 0);
      step(1'b0, none);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/onchip_mem_arbiter.md
# onchip_mem_arbiter

Two-master arbiter that shares the single-port on-chip memory (9-bit word address, 32-bit data, byte enables, write gated by debugaccess, one-cycle read latency) between the Nios data master (port 0) and the debug/loader master (port 1). It grants one Avalon-style transfer per cycle using round-robin priority. It drives the memory's address, control and clock-enable inputs, tags each read, and returns registered read data with readdatavalid to the master that issued the read. The block sits between the system interconnect and the memory instance.

## Interface
- ADDR_W, 9: word address width.
- DATA_W, 32: data width; byte enable width is DATA_W/8.
- clk  in  1  system clock; all registers rise-edge.
- reset_n  in  1  asynchronous, active-low reset.
- mN_address  in  ADDR_W  word address, master N (N = 0, 1).
- mN_byteenable  in  DATA_W/8  byte lanes, master N.
- mN_read  in  1  read request, master N.
- mN_write  in  1  write request, master N.
- mN_writedata  in  DATA_W  write data, master N.
- mN_debugaccess  in  1  write permission qualifier, master N.
- mN_waitrequest  out  1  request not accepted this cycle.
- mN_readdata  out  DATA_W  registered read data.
- mN_readdatavalid  out  1  one-cycle strobe; mN_readdata is valid.
- mem_address  out  ADDR_W  to memory address.
- mem_byteenable  out  DATA_W/8  to memory byteenable.
- mem_chipselect  out  1  to memory chipselect.
- mem_write  out  1  to memory write.
- mem_writedata  out  DATA_W  to memory writedata.
- mem_debugaccess  out  1  to memory debugaccess.
- mem_clken  out  1  to memory clken; held at 1 out of reset.
- mem_readdata  in  DATA_W  from memory; valid one cycle after a read is issued.

## Operation
- Request: reqN = mN_read | mN_write. If mN_read and mN_write are both high, the write is taken and the read is ignored for that transfer.
- Grant (combinational): if only one master requests, that master is granted. If both request, the master not granted last time wins. The last_grant register updates only on an accepted transfer and resets to 1, so m0 wins the first tie.
- mN_waitrequest = reqN & ~grantN. While reset_n is low, both waitrequests are 1.
- Memory side (combinational mux of the granted master): mem_chipselect = any grant; the address, byteenable, writedata, write and debugaccess pass through from the granted master. With no grant, mem_chipselect = 0, mem_write = 0 and the other outputs are 0.
- Writes complete in the accept cycle and return no response. A write without debugaccess is accepted, but the memory ignores it and the contents are unchanged.
- Read pipeline:
  - Stage 1 registers rd_pend and rd_tag (the granted port) at the accept edge.
  - Stage 2 captures mem_readdata into mN_readdata, for the tagged port only, at the next edge, and pulses mN_readdatavalid.
  - The readdata of the other port holds its previous value.
- Reads are fully pipelined: one new read per cycle, and the return order equals the issue order.
- Reset values: last_grant = 1, rd_pend = 0, rd_tag = 0, both readdatavalid = 0, both readdata = 0, mem_clken = 0 while in reset and 1 afterwards.
- Reset mid-operation: all in-flight reads are discarded. After reset deasserts, no readdatavalid is produced for a read accepted before reset.

## Timing
- Accept at edge T (request high, waitrequest low). The memory registers the address at T. mem_readdata is valid during T..T+1. mN_readdatavalid is high for exactly the cycle after edge T+1, so read latency is 2 cycles from accept.
- Throughput: one transfer per cycle in total. Under continuous contention each master gets every other cycle.
- A master must hold its address, data and control stable while waitrequest is high.
- A read and a write may be accepted on consecutive cycles in either order. A read after a write to the same address returns the new data, because the write completes at its accept edge.

## Test plan
- Reset: hold reset_n low with both masters requesting -> both waitrequests = 1, mem_chipselect = 0, both readdatavalid = 0. First tie after release is granted to m0.
- Single read: m1 writes 0xDEADBEEF to address 0x05 with debugaccess=1, byteenable=0xF; m1 then reads 0x05 -> m1_readdatavalid goes high 2 cycles after accept with 0xDEADBEEF; m0_readdatavalid stays 0.
- Contention: both masters request reads continuously for 8 cycles -> grants alternate m0, m1, m0, …; each master gets 4 readdatavalid pulses in order with the correct data.
- Write protect: m0 writes 0x12345678 to address 0x05 with debugaccess=0 -> the write is accepted (waitrequest low); a following read returns 0xDEADBEEF.
- Byte lanes: write 0x000000AA to address 0x1FF with byteenable=0x1 -> reading address 0x1FF returns the previous upper bytes with low byte 0xAA.
- Reset mid-read: assert reset_n for one cycle right after a read is accepted -> no readdatavalid for that read; the next read completes normally.
